// File: rtl/systolic_feeder_2x2.sv
// Skews one 2x2 A/B job at a time into a systolic array and returns the array's
// results in acceptance order through a four-entry FIFO, with credit-based flow control.
module systolic_feeder_2x2 #(
  parameter int DATA_WIDTH = 4,
  parameter int ACC_WIDTH  = 9,
  parameter int RES_LAT    = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_a00,
  input  logic [DATA_WIDTH-1:0] s_a01,
  input  logic [DATA_WIDTH-1:0] s_a10,
  input  logic [DATA_WIDTH-1:0] s_a11,
  input  logic [DATA_WIDTH-1:0] s_b00,
  input  logic [DATA_WIDTH-1:0] s_b01,
  input  logic [DATA_WIDTH-1:0] s_b10,
  input  logic [DATA_WIDTH-1:0] s_b11,
  output logic                  arr_in_valid,
  output logic [DATA_WIDTH-1:0] arr_a00,
  output logic [DATA_WIDTH-1:0] arr_a01,
  output logic [DATA_WIDTH-1:0] arr_a10,
  output logic [DATA_WIDTH-1:0] arr_a11,
  output logic [DATA_WIDTH-1:0] arr_b00,
  output logic [DATA_WIDTH-1:0] arr_b01,
  output logic [DATA_WIDTH-1:0] arr_b10,
  output logic [DATA_WIDTH-1:0] arr_b11,
  input  logic                  arr_out_valid,
  input  logic [ACC_WIDTH-1:0]  arr_c00,
  input  logic [ACC_WIDTH-1:0]  arr_c01,
  input  logic [ACC_WIDTH-1:0]  arr_c10,
  input  logic [ACC_WIDTH-1:0]  arr_c11,
  output logic                  r_valid,
  input  logic                  r_ready,
  output logic [ACC_WIDTH-1:0]  r_c00,
  output logic [ACC_WIDTH-1:0]  r_c01,
  output logic [ACC_WIDTH-1:0]  r_c10,
  output logic [ACC_WIDTH-1:0]  r_c11,
  output logic                  err
);

  localparam int CAP = 4 + RES_LAT;

  // vld_p[k] is set while some job sits at issue offset T+k
  logic [CAP:0] vld_p;
  logic         ready_en;
  logic [2:0]   credits;
  logic         accept;
  logic         pop;
  logic         capture;

  logic [DATA_WIDTH-1:0] b00_p0, b10_p0, b11_p0, a00_p0, a01_p0, a10_p0, a11_p0;
  logic [DATA_WIDTH-1:0] b11_p1, a00_p1, a01_p1, a10_p1, a11_p1;
  logic [DATA_WIDTH-1:0] a01_p2, a10_p2, a11_p2;
  logic [DATA_WIDTH-1:0] a11_p3;

  logic [4*ACC_WIDTH-1:0] mem [4];
  logic [4*ACC_WIDTH-1:0] head;
  logic [1:0]             wr_ptr;
  logic [1:0]             rd_ptr;
  logic [2:0]             count;

  // vld_p[0] marks the cycle right after an acceptance, which doubles as the cadence hold-off
  assign s_ready = ready_en & ~vld_p[0] & (credits != 3'd4);
  assign accept  = s_valid & s_ready;
  assign pop     = r_valid & r_ready;
  assign capture = vld_p[CAP];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ready_en <= 1'b0;
      vld_p    <= '0;
      credits  <= 3'd0;
      err      <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      vld_p    <= {vld_p[CAP-1:0], accept};
      case ({accept, pop})
        2'b10:   credits <= credits + 3'd1;
        2'b01:   credits <= credits - 3'd1;
        default: credits <= credits;
      endcase
      if (capture && !arr_out_valid) err <= 1'b1;
    end
  end

  // p0: job as accepted
  always_ff @(posedge clk) begin
    b00_p0 <= s_b00;
    b10_p0 <= s_b10;
    b11_p0 <= s_b11;
    a00_p0 <= s_a00;
    a01_p0 <= s_a01;
    a10_p0 <= s_a10;
    a11_p0 <= s_a11;
    // p1
    b11_p1 <= b11_p0;
    a00_p1 <= a00_p0;
    a01_p1 <= a01_p0;
    a10_p1 <= a10_p0;
    a11_p1 <= a11_p0;
    // p2
    a01_p2 <= a01_p1;
    a10_p2 <= a10_p1;
    a11_p2 <= a11_p1;
    // p3
    a11_p3 <= a11_p2;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      arr_in_valid <= 1'b0;
      arr_b01      <= '0;
      arr_b00      <= '0;
      arr_b10      <= '0;
      arr_b11      <= '0;
      arr_a00      <= '0;
      arr_a01      <= '0;
      arr_a10      <= '0;
      arr_a11      <= '0;
    end else begin
      arr_in_valid <= |vld_p[3:1];
      arr_b01      <= accept   ? s_b01  : '0;
      arr_b00      <= vld_p[0] ? b00_p0 : '0;
      arr_b10      <= vld_p[0] ? b10_p0 : '0;
      arr_b11      <= vld_p[1] ? b11_p1 : '0;
      arr_a00      <= vld_p[1] ? a00_p1 : '0;
      arr_a01      <= vld_p[2] ? a01_p2 : '0;
      arr_a10      <= vld_p[2] ? a10_p2 : '0;
      arr_a11      <= vld_p[3] ? a11_p3 : '0;
    end
  end

  // result FIFO: pointers are control, storage is plain data
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (capture) wr_ptr <= wr_ptr + 2'd1;
      if (pop)     rd_ptr <= rd_ptr + 2'd1;
      case ({capture, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (capture) mem[wr_ptr] <= {arr_c11, arr_c10, arr_c01, arr_c00};
  end

  assign r_valid = (count != 3'd0);
  assign head    = mem[rd_ptr];
  assign r_c00   = r_valid ? head[ACC_WIDTH-1:0]             : '0;
  assign r_c01   = r_valid ? head[2*ACC_WIDTH-1:ACC_WIDTH]   : '0;
  assign r_c10   = r_valid ? head[3*ACC_WIDTH-1:2*ACC_WIDTH] : '0;
  assign r_c11   = r_valid ? head[4*ACC_WIDTH-1:3*ACC_WIDTH] : '0;

endmodule

// File: tb/tb_systolic_feeder_2x2.sv
// Bench for systolic_feeder_2x2: a fixed single-job vector table, hand-written
// cadence/backpressure/error/reset sequences, and random traffic against a job-list model.
module tb_systolic_feeder_2x2;
  localparam int DW = 4;
  localparam int AW = 9;
  localparam int RL = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rstn, s_valid, r_ready, arr_out_valid;
  logic [3:0][DW-1:0]  s_a, s_b;
  logic [3:0][AW-1:0]  arr_c;
  wire                 s_ready, arr_in_valid, r_valid, err;
  wire  [3:0][DW-1:0]  arr_a, arr_b;
  wire  [3:0][AW-1:0]  r_c;

  systolic_feeder_2x2 #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .RES_LAT(RL)) dut (
    .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready),
    .s_a00(s_a[0]), .s_a01(s_a[1]), .s_a10(s_a[2]), .s_a11(s_a[3]),
    .s_b00(s_b[0]), .s_b01(s_b[1]), .s_b10(s_b[2]), .s_b11(s_b[3]),
    .arr_in_valid(arr_in_valid),
    .arr_a00(arr_a[0]), .arr_a01(arr_a[1]), .arr_a10(arr_a[2]), .arr_a11(arr_a[3]),
    .arr_b00(arr_b[0]), .arr_b01(arr_b[1]), .arr_b10(arr_b[2]), .arr_b11(arr_b[3]),
    .arr_out_valid(arr_out_valid),
    .arr_c00(arr_c[0]), .arr_c01(arr_c[1]), .arr_c10(arr_c[2]), .arr_c11(arr_c[3]),
    .r_valid(r_valid), .r_ready(r_ready),
    .r_c00(r_c[0]), .r_c01(r_c[1]), .r_c10(r_c[2]), .r_c11(r_c[3]),
    .err(err)
  );

  typedef struct {
    logic sv, rr, ov;
    logic [3:0][DW-1:0] a, b;
    logic [3:0][AW-1:0] c;
  } in_t;
  typedef struct {
    logic rdy, iv, rv, er;
    logic [3:0][DW-1:0] a, b;
    logic [AW-1:0] rc00;
  } exp_t;
  typedef struct { in_t in; exp_t ex; } vec_t;
  typedef struct { int t; logic [3:0][DW-1:0] a, b; } job_t;

  job_t               jobs[$];
  logic [3:0][AW-1:0] res_q[$];
  int   cyc_n = 0, last_acc = -100, credits = 0, dut_acc = 0;
  logic err_m = 1'b0;
  int   checks = 0, errors = 0;
  exp_t nx;
  vec_t tab[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc_n, act, req);
    end
  endtask

  task automatic model_reset();
    jobs.delete();
    res_q.delete();
    last_acc = -100;
    credits  = 0;
    err_m    = 1'b0;
  endtask

  task automatic drive(input in_t v);
    s_valid = v.sv; r_ready = v.rr; arr_out_valid = v.ov;
    s_a = v.a; s_b = v.b; arr_c = v.c;
  endtask

  function automatic in_t mk(input logic sv, input logic rr, input logic ov);
    in_t v;
    v.sv = sv; v.rr = rr; v.ov = ov;
    for (int k = 0; k < 4; k++) begin
      v.a[k] = DW'($urandom);
      v.b[k] = DW'($urandom);
      v.c[k] = AW'($urandom);
    end
    return v;
  endfunction

  // One clock cycle: drive at the falling edge, check 1ns later, advance the model.
  task automatic cyc(input in_t v, input bit use_tab, input exp_t e);
    logic [3:0][DW-1:0] ma, mb;
    logic [3:0][AW-1:0] mrc;
    logic miv, mrdy, mrv;
    int d;
    job_t j;
    drive(v);
    #1;
    ma = '0; mb = '0; miv = 1'b0;
    foreach (jobs[i]) begin
      d = cyc_n - (jobs[i].t + 1);
      case (d)
        0: mb[1] |= jobs[i].b[1];
        1: begin mb[0] |= jobs[i].b[0]; mb[2] |= jobs[i].b[2]; end
        2: begin mb[3] |= jobs[i].b[3]; ma[0] |= jobs[i].a[0]; end
        3: begin ma[1] |= jobs[i].a[1]; ma[2] |= jobs[i].a[2]; end
        4: ma[3] |= jobs[i].a[3];
        default: ;
      endcase
      if (d >= 2 && d <= 4) miv = 1'b1;
    end
    mrdy = (last_acc != cyc_n - 1) && (credits < 4);
    mrv  = (res_q.size() > 0);
    mrc  = mrv ? res_q[0] : '0;
    chk("s_ready",  64'(s_ready),        64'(mrdy));
    chk("lanes",    64'({arr_a, arr_b}), 64'({ma, mb}));
    chk("in_valid", 64'(arr_in_valid),   64'(miv));
    chk("r_valid",  64'(r_valid),        64'(mrv));
    chk("r_c",      64'(r_c),            64'(mrc));
    chk("err",      64'(err),            64'(err_m));
    if (use_tab) begin
      chk("tab_s_ready",  64'(s_ready),        64'(e.rdy));
      chk("tab_lanes",    64'({arr_a, arr_b}), 64'({e.a, e.b}));
      chk("tab_in_valid", 64'(arr_in_valid),   64'(e.iv));
      chk("tab_r_valid",  64'(r_valid),        64'(e.rv));
      chk("tab_r_c00",    64'(r_c[0]),         64'(e.rc00));
      chk("tab_err",      64'(err),            64'(e.er));
    end
    if (v.sv && s_ready) dut_acc++;
    if (v.sv && mrdy) begin
      j.t = cyc_n; j.a = v.a; j.b = v.b;
      jobs.push_back(j);
      last_acc = cyc_n;
      credits++;
    end
    if (v.rr && mrv) begin
      void'(res_q.pop_front());
      credits--;
    end
    if (jobs.size() > 0 && jobs[0].t + 5 + RL == cyc_n) begin
      res_q.push_back(v.c);
      if (!v.ov) err_m = 1'b1;
      void'(jobs.pop_front());
    end
    cyc_n++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    drive(mk(1'b0, 1'b0, 1'b0));
    #1;
    chk("rst_s_ready",  64'(s_ready),        64'(0));
    chk("rst_lanes",    64'({arr_a, arr_b}), 64'(0));
    chk("rst_in_valid", 64'(arr_in_valid),   64'(0));
    chk("rst_r_valid",  64'(r_valid),        64'(0));
    chk("rst_r_c",      64'(r_c),            64'(0));
    chk("rst_err",      64'(err),            64'(0));
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int a0;
    in_t jv;
    nx = '{default: '0};
    for (int i = 0; i < 10; i++) begin
      tab[i].in.sv = 1'b0; tab[i].in.rr = 1'b1; tab[i].in.ov = 1'b0;
      tab[i].in.a  = {4'd6, 4'd13, 4'd1, 4'd5};
      tab[i].in.b  = {4'd9, 4'd14, 4'd10, 4'd6};
      tab[i].in.c  = '0;
      tab[i].ex    = '{rdy: 1'b1, iv: 1'b0, rv: 1'b0, er: 1'b0, a: '0, b: '0, rc00: '0};
    end
    tab[0].in.sv = 1'b1;
    tab[1].ex.rdy = 1'b0; tab[1].ex.b[1] = 4'd10;
    tab[2].ex.b[0] = 4'd6; tab[2].ex.b[2] = 4'd14;
    tab[3].ex.b[3] = 4'd9; tab[3].ex.a[0] = 4'd5;  tab[3].ex.iv = 1'b1;
    tab[4].ex.a[1] = 4'd1; tab[4].ex.a[2] = 4'd13; tab[4].ex.iv = 1'b1;
    tab[5].ex.a[3] = 4'd6; tab[5].ex.iv = 1'b1;
    tab[7].in.ov = 1'b1; tab[7].in.c[0] = 9'd100;
    tab[8].ex.rv = 1'b1; tab[8].ex.rc00 = 9'd100;

    rstn = 1'b1;
    drive(mk(1'b0, 1'b0, 1'b0));
    @(negedge clk);
    do_reset();

    for (int i = 0; i < 10; i++) cyc(tab[i].in, 1'b1, tab[i].ex);

    // s_valid held: acceptances every other cycle
    a0 = dut_acc;
    for (int i = 0; i < 5; i++) cyc(mk(1'b1, 1'b1, 1'b1), 1'b0, nx);
    chk("burst_accepts", 64'(dut_acc - a0), 64'(3));
    for (int i = 0; i < 14; i++) cyc(mk(1'b0, 1'b1, 1'b1), 1'b0, nx);

    // results never drained: credits cap acceptance at four jobs
    a0 = dut_acc;
    for (int i = 0; i < 16; i++) cyc(mk(1'b1, 1'b0, 1'b1), 1'b0, nx);
    chk("bp_accepts", 64'(dut_acc - a0), 64'(4));
    chk("bp_s_ready", 64'(s_ready), 64'(0));
    cyc(mk(1'b0, 1'b1, 1'b1), 1'b0, nx);
    chk("bp_ready_after_pop", 64'(s_ready), 64'(1));
    a0 = dut_acc;
    cyc(mk(1'b1, 1'b0, 1'b1), 1'b0, nx);
    chk("bp_fifth_accept", 64'(dut_acc - a0), 64'(1));
    for (int i = 0; i < 24; i++) cyc(mk(1'b0, 1'b1, 1'b1), 1'b0, nx);

    // array fails to flag its result at the capture cycle
    cyc(mk(1'b1, 1'b1, 1'b0), 1'b0, nx);
    for (int i = 0; i < 12; i++) cyc(mk(1'b0, 1'b1, 1'b0), 1'b0, nx);
    chk("err_sticky", 64'(err), 64'(1));
    for (int i = 0; i < 4; i++) cyc(mk(1'b0, 1'b1, 1'b1), 1'b0, nx);
    chk("err_still_set", 64'(err), 64'(1));

    // reset during cycle 3 of a job
    jv = tab[0].in; jv.ov = 1'b1;
    cyc(jv, 1'b0, nx);
    cyc(mk(1'b0, 1'b1, 1'b1), 1'b0, nx);
    cyc(mk(1'b0, 1'b1, 1'b1), 1'b0, nx);
    do_reset();
    chk("post_rst_ready", 64'(s_ready), 64'(1));
    for (int i = 0; i < 15; i++) cyc(mk(1'b0, 1'b1, 1'b1), 1'b0, nx);

    for (int i = 0; i < 400; i++)
      cyc(mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 15) != 0)), 1'b0, nx);
    do_reset();
    for (int i = 0; i < 400; i++)
      cyc(mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), 1'b1), 1'b0, nx);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/systolic_feeder_2x2.md
SYSTOLIC_FEEDER_2X2 -- requirements
Module: systolic_feeder_2x2

Interface
REQ-001 Parameters: DATA_WIDTH, 4, operand width; ACC_WIDTH, 9, result width; RES_LAT, 2, array latency in cycles from the last data beat to the valid result.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 s_valid / s_ready  input / output  1 / 1  job handshake; a job transfers on a cycle with s_valid=1 and s_ready=1.
REQ-005 s_a00, s_a01, s_a10, s_a11  input  DATA_WIDTH each  unskewed data matrix A.
REQ-006 s_b00, s_b01, s_b10, s_b11  input  DATA_WIDTH each  unskewed weight matrix B.
REQ-007 arr_in_valid  output  1  array in_valid.
REQ-008 arr_a00..arr_a11, arr_b00..arr_b11  output  DATA_WIDTH each  skewed lanes to the array.
REQ-009 arr_out_valid  input  1; arr_c00..arr_c11  input  ACC_WIDTH each  array results.
REQ-010 r_valid / r_ready  output / input  1 / 1  result handshake; r_c00..r_c11  output  ACC_WIDTH each.
REQ-011 err  output  1  sticky protocol error flag.

Function
REQ-012 A job accepted in cycle t has issue start T=t+1; all lanes are registered outputs.
REQ-013 Issue schedule:
- T: arr_b01=B01.
- T+1: arr_b00=B00, arr_b10=B10.
- T+2: arr_b11=B11, arr_a00=A00.
- T+3: arr_a01=A01, arr_a10=A10.
- T+4: arr_a11=A11.
REQ-014 Lanes not scheduled in a cycle drive 0; lanes of overlapping jobs OR together, and the schedule guarantees that no lane collides.
REQ-015 arr_in_valid=1 in every cycle where any job is in its data phase (T+2..T+4), and 0 otherwise.
REQ-016 Issue cadence: a new issue start occurs no sooner than 2 cycles after the previous one, so s_ready=0 in the cycle after an acceptance.
REQ-017 Credit counter 0..4 = jobs in flight + results buffered; it increments on acceptance and decrements on a result pop; the two events in the same cycle leave it unchanged.
REQ-018 s_ready = cadence slot free AND credits<4, combinational from registers only (no dependence on s_valid).
REQ-019 Capture: at cycle T+4+RES_LAT of each job, arr_c00..arr_c11 are written into a 4-entry result FIFO; the capture is unconditional.
REQ-020 If arr_out_valid=0 in a capture cycle, err is set to 1 and the captured data is still stored.
REQ-021 arr_out_valid=1 outside any capture cycle has no effect.
REQ-022 Result FIFO:
- r_valid=1 when not empty; head shown on r_c*.
- Pop on r_valid AND r_ready.
- Push visible on r_valid the cycle after capture.
- Simultaneous push and pop at any occupancy is legal.
- Overflow is impossible by credit rule.
REQ-023 Result order equals job acceptance order; the result data is not modified (no saturation or truncation).
REQ-024 err clears only by reset.

Reset
REQ-025 While rstn=0 (asynchronous), the outputs are: s_ready=0, arr_in_valid=0, all arr_a*/arr_b*=0, r_valid=0, r_c*=0, err=0.
REQ-026 While rstn=0, credits, cadence and FIFO are cleared, and in-flight jobs are discarded with no capture.
REQ-027 s_ready=1 in the first cycle after rstn deasserts.
REQ-028 Reset mid-operation is equivalent to power-on reset, and no partial lane pattern resumes.

Verification
REQ-029 Single job A={5,1,13,6}, B={6,10,14,9} accepted at cycle 0 -> lanes:
- cycle 1: b01=10.
- cycle 2: b00=6, b10=14.
- cycle 3: b11=9, a00=5.
- cycle 4: a01=1, a10=13.
- cycle 5: a11=6.
- arr_in_valid=1 at cycles 3..5.
REQ-030 Same job, arr_out_valid=1 and arr_c00=100 at cycle 7 -> r_valid=1 at cycle 8 with r_c00=100; err=0.
REQ-031 s_valid held high for 3 jobs -> acceptances at cycles 0, 2 and 4; s_ready=0 at cycles 1 and 3; no lane collision; results in order.
REQ-032 r_ready=0 with 5 offered jobs -> 4 accepted and s_ready stays 0; one pop -> s_ready=1 the next cycle and the 5th job is accepted.
REQ-033 arr_out_valid=0 at a capture cycle -> err=1 permanently, and the result is still delivered.
REQ-034 rstn pulsed low at cycle 3 of a job -> all outputs 0 immediately; no result after release; s_ready=1 the first cycle after release.
